// File: rtl/tdm_demux4.sv
// Receive-side TDM demultiplexer: reassembles 4-slot serial frames into a registered
// 4-bit word, tracks the slot position as {s0,s1} and flags frame-sync misalignment.
module tdm_demux4 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             sync,
    input  logic             err_clr,
    output logic [3:0]       out,
    output logic             valid,
    output logic             s0,
    output logic             s1,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned SLOT_W = 2;
    localparam int unsigned SHD_W  = 3;
    localparam int unsigned OUT_W  = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [SHD_W-1:0]   shadow_q, shadow_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            slot_q   <= '0;
            shadow_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; a misalignment set on the same edge overrides err_clr
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        err_d    = err_q & ~err_clr;
        cnt_d    = cnt_q;

        if (en) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_d      = SLOT_W'(1);
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync && (slot_q != '0)) begin
                        // Drop the partial frame and restart at slot 1
                        err_d       = 1'b1;
                        shadow_d[0] = din;
                        slot_d      = SLOT_W'(1);
                    end else begin
                        case (slot_q)
                            2'd0: shadow_d[0] = din;
                            2'd1: shadow_d[1] = din;
                            2'd2: shadow_d[2] = din;
                            default: begin
                                out_d   = {din, shadow_q};
                                valid_d = 1'b1;
                                cnt_d   = cnt_q + CNT_W'(1);
                            end
                        endcase
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign out       = out_q;
    assign valid     = valid_q;
    assign s0        = slot_q[1];
    assign s1        = slot_q[0];
    assign locked    = (state_q == LOCKED);
    assign err       = err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Receive-side companion to the team's 4:1 multiplexer. It takes a serial time-division stream in which four lanes are interleaved one bit per slot, and tracks the slot position with a 2-bit counter exposed as s0/s1, using the same select encoding as the mux. It reassembles each complete 4-slot frame into a registered 4-bit word with a one-cycle valid pulse. It also detects frame-sync misalignment.

## Interface
Parameters:
- CNT_W, default 8: width of the completed-frame counter.

Ports:
- clk, input, 1: sole clock; all state updates on rising edge.
- rst_n, input, 1: reset, synchronous, active-low; sampled on rising edge of clk.
- en, input, 1: sample strobe; din/sync are consumed only on cycles with en=1.
- din, input, 1: serial data bit for the current slot.
- sync, input, 1: frame marker; 1 means this sample belongs to slot 0. Qualified by en.
- err_clr, input, 1: clears sticky err.
- out, output, 4: last complete frame; out[k] is the bit received in slot k.
- valid, output, 1: one-cycle pulse when out is updated.
- s0, output, 1: MSB of the expected next slot; slot = {s0,s1} (mux encoding: in[0]=00, in[1]=01, in[2]=10, in[3]=11).
- s1, output, 1: LSB of the expected next slot.
- locked, output, 1: 1 in LOCKED state.
- err, output, 1: sticky sync-misalignment flag.
- frame_cnt, output, CNT_W: completed frames, wraps modulo 2^CNT_W.

## Operation
- Internal: 2-bit slot counter (drives {s0,s1}), 3-bit shadow register for slots 0..2, 1-bit state {HUNT, LOCKED}.
- Reset (rst_n=0 at an edge), regardless of state or en:
  - State goes to HUNT.
  - Slot, shadow, out, valid, err and frame_cnt all go to 0, so locked=0.
- HUNT, en=1 and sync=0: sample ignored; slot stays 0.
- HUNT, en=1 and sync=1:
  - shadow[0] ← din, slot ← 1, go to LOCKED.
- LOCKED, en=1 and sync=0: the sample goes to the current slot.
  - Slot 0, 1 or 2: shadow[slot] ← din, then slot increments.
  - Slot 3: out ← {din, shadow[2], shadow[1], shadow[0]}, valid ← 1, frame_cnt increments (wraps), slot ← 0.
- LOCKED, en=1 and sync=1 at slot 0: treated as a normal slot-0 sample. Sync at slot 0 is optional in LOCKED; the counter free-runs.
- LOCKED, en=1 and sync=1 at slot ≠ 0 (misalignment):
  - err ← 1.
  - The partial frame is discarded: out, valid and frame_cnt are unchanged.
  - shadow[0] ← din, slot ← 1; state stays LOCKED (immediate resync).
- en=0: no state change, except that valid is cleared and err_clr is still honoured.
- err_clr=1 clears err, unless a misalignment is detected on the same edge; then err stays 1 (set wins).
- Once entered, LOCKED is left only by reset.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: the slot-3 sample taken at edge N appears on out, with valid=1, during the cycle after edge N.
- valid is high for exactly one cycle; back-to-back frames (en held high) give valid every 4th cycle.
- {s0,s1} shows the slot for the next en sample and updates on the same edge as the sample.
- Reset mid-frame drops the partial frame; out returns to 0 on the next cycle.

## Test plan
- Reset: rst_n=0 for 2 cycles with random inputs → out=0000, valid=0, locked=0, err=0, frame_cnt=0, {s0,s1}=00.
- Lock and capture: with en=1, send sync=1/din=1, then din=1,0,1 → one cycle later out=1011 (out[0]=1, out[1]=1, out[2]=0, out[3]=1), valid=1 for one cycle, frame_cnt=1; {s0,s1} sequence 01,10,11,00.
- Hunt rejection: in HUNT, 5 samples with sync=0 → locked=0, slot stays 00, no valid. Then sync=1 → locked=1.
- Gapped strobe: same frame as lock-and-capture, with en=0 for 3 cycles between each sample → identical out=1011, a single valid pulse, no change while en=0.
- Misalignment: after lock, sync=1 at slot 2 → err=1, no valid, {s0,s1}=01. The next 3 samples 0,0,0 then complete frame 0 (out[0]= din of the sync sample). Then err_clr=1 with no new error → err=0; err_clr coincident with another misalignment → err stays 1.
- Wrap: CNT_W=2, 5 continuous frames → frame_cnt sequence 1,2,3,0,1, valid pulse every 4 cycles.
